writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/register_file.sv | 40 ++++
 rtl/writeback_unit.sv | 79 +++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath words, register selects, instruction views
// and the writeback halt-state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    logic [5:0] opcode;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_t;

  typedef struct packed {
    logic [5:0]  opcode;
    regbits_t    rs;
    regbits_t    rt;
    logic [15:0] imm;
  } i_t;

  localparam regbits_t REG_RA = 5'd31;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two async read ports, one write port; r0 hardwired 0.
// Define WB_BYPASS_EN to make reads of the register being written return the new data.
module register_file
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     WEN,
  input  regbits_t wsel,
  input  word_t    wdat,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output word_t    rdat1,
  output word_t    rdat2
);

  word_t regs_q [31:1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (WEN && (wsel != '0)) begin
      regs_q[wsel] <= wdat;
    end
  end

  function automatic word_t rd_port(input regbits_t sel);
    word_t v;
    if (sel == '0) v = '0;
`ifdef WB_BYPASS_EN
    else if (WEN && (sel == wsel)) v = wdat;
`endif
    else v = regs_q[sel];
    return v;
  endfunction

  assign rdat1 = rd_port(rsel1);
  assign rdat2 = rd_port(rsel2);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: destination/data select, halt FSM, retire counter and register file.
// Write-first bypass in the register file is enabled by defining WB_BYPASS_EN.
module writeback_unit
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  word_t    instruction_in,
  input  word_t    pc4_in,
  input  word_t    outport_in,
  input  word_t    dload_in,
  input  logic     RegWrite_in,
  input  logic     MemtoReg_in,
  input  logic     RegDst_in,
  input  logic     jal_in,
  input  logic     halt_in,
  input  logic     wb_advance,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output word_t    rdat1,
  output word_t    rdat2,
  output regbits_t wsel_out,
  output word_t    wdat_out,
  output logic     wen_out,
  output logic     halted,
  output word_t    retired
);

  wb_state_t state_q, state_d;
  word_t     retired_q, retired_d;
  r_t        instr_r;
  i_t        instr_i;

  assign instr_r = r_t'(instruction_in);
  assign instr_i = i_t'(instruction_in);

  assign wsel_out = jal_in    ? REG_RA     :
                    RegDst_in ? instr_r.rd : instr_i.rt;
  assign wdat_out = jal_in      ? pc4_in   :
                    MemtoReg_in ? dload_in : outport_in;

  // The halt instruction itself never writes, and nothing writes once halted.
  assign wen_out = RegWrite_in & (wsel_out != '0) & ~halted & ~halt_in;

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    if (state_q == WB_RUN) begin
      if (wb_advance && (instruction_in != '0)) retired_d = retired_q + 32'd1;
      if (halt_in) state_d = WB_HALTED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= WB_RUN;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign halted  = (state_q == WB_HALTED);
  assign retired = retired_q;

  register_file u_rf (
    .CLK   (CLK),
    .nRST  (nRST),
    .WEN   (wen_out),
    .wsel  (wsel_out),
    .wdat  (wdat_out),
    .rsel1 (rsel1),
    .rsel2 (rsel2),
    .rdat1 (rdat1),
    .rdat2 (rdat2)
  );

endmodule
